dac_btn_ctrl: RTL and testbench

Controller that turns debounced BTN_WEST / BTN_EAST presses into 12-bit level changes and sequences a 32-bit LTC2624 write-and-update frame over SPI for each change. It sits between the board buttons and the DAC pins of the Spartan-3 starter-kit DAC design. It owns the whole SPI transaction: chip select, serial clock, data and the DAC clear line.

---
 rtl/dac_btn_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dac_btn_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_btn_ctrl.sv
// dac_btn_ctrl
// Turns debounced BTN_WEST / BTN_EAST presses into saturating 12-bit level
// steps and sends one LTC2624 write-and-update frame (32 bits, MSB first)
// over SPI for each change. Presses that arrive mid-frame merge into a
// single follow-up frame carrying the newest level.
//
// Ports
//   CLK50MHZ   in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   BTN_WEST   in   async button, press adds STEP
//   BTN_EAST   in   async button, press subtracts STEP
//   SPI_SCK    out  SPI clock, idles low
//   SPI_MOSI   out  serial data, MSB first
//   DAC_CS     out  chip select, active low
//   DAC_CLR    out  DAC clear, active low
//   LEVEL      out  current DAC code (12 bits)
//   BUSY       out  high while a frame (incl. CS-high hold) is in progress
//   FRAME_DONE out  one-cycle pulse in the last hold cycle
module dac_btn_ctrl #(
    parameter logic [11:0] STEP     = 12'd256,
    parameter int          DEBOUNCE = 16,
    parameter int          SCK_DIV  = 2,
    parameter logic [3:0]  DAC_ADDR = 4'b1111
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        BTN_WEST,
    input  logic        BTN_EAST,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        DAC_CS,
    output logic        DAC_CLR,
    output logic [11:0] LEVEL,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int DW = $clog2(SCK_DIV + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t state, state_nxt;

    // index 0 = west, 1 = east
    logic [1:0]         btn, sync1, sync2, db, db_q, press;
    logic [1:0][CW-1:0] db_cnt;

    logic          pending;
    logic [DW-1:0] div_cnt;
    logic [5:0]    half_cnt;
    logic [31:0]   shreg;
    logic          div_wrap, start;
    logic [12:0]   sum, diff;
    logic [11:0]   up, dn;

    assign btn      = {BTN_EAST, BTN_WEST};
    assign press    = db & ~db_q;
    assign div_wrap = (div_cnt == DW'(SCK_DIV - 1));
    // shreg shifts in zeros, so MOSI is back to 0 once all 32 bits are out
    assign SPI_MOSI = shreg[31];

    // 13-bit arithmetic so overflow/underflow show up in bit 12
    always_comb begin
        sum  = {1'b0, LEVEL} + {1'b0, STEP};
        diff = {1'b0, LEVEL} - {1'b0, STEP};
        up   = sum[12]  ? 12'hFFF : sum[11:0];
        dn   = diff[12] ? 12'h000 : diff[11:0];
    end

    // Synchronizer + stability counter per button
    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            sync1  <= '0;
            sync2  <= '0;
            db     <= '0;
            db_q   <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DEBOUNCE - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        BUSY       = (state != IDLE);
        FRAME_DONE = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    state_nxt = SHIFT;
                    start     = 1'b1;
                end
            end
            SHIFT: begin
                // 64th SCK toggle is the 32nd falling edge
                if (div_wrap && half_cnt == 6'd63) state_nxt = HOLD;
            end
            HOLD: begin
                if (div_wrap) begin
                    state_nxt  = IDLE;
                    FRAME_DONE = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            SPI_SCK  <= 1'b0;
            DAC_CS   <= 1'b1;
            DAC_CLR  <= 1'b0;
            LEVEL    <= '0;
            pending  <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
        end else begin
            DAC_CLR <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= {8'h00, 4'b0011, DAC_ADDR, LEVEL, 4'h0};
                        div_cnt  <= '0;
                        half_cnt <= '0;
                        SPI_SCK  <= 1'b0;
                        DAC_CS   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (div_wrap) begin
                        div_cnt  <= '0;
                        SPI_SCK  <= ~SPI_SCK;
                        half_cnt <= half_cnt + 6'd1;
                        if (SPI_SCK) shreg <= {shreg[30:0], 1'b0};
                        if (half_cnt == 6'd63) DAC_CS <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
                end
                default: ;
            endcase

            // a press landing on the start cycle must survive the clear
            if (start) pending <= 1'b0;
            if (press[0] && !press[1] && LEVEL != 12'hFFF) begin
                LEVEL   <= up;
                pending <= 1'b1;
            end else if (press[1] && !press[0] && LEVEL != 12'h000) begin
                LEVEL   <= dn;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_btn_ctrl.sv
// Testbench for dac_btn_ctrl: a behavioural frame/level model checked every
// cycle, plus a serial-frame capture monitor and literal expectations.
module tb_dac_btn_ctrl;

    localparam int DEB       = 16;
    localparam int DIV       = 2;
    localparam int FRAME_CS  = 64 * DIV;       // cycles with CS low
    localparam int FRAME_LEN = FRAME_CS + DIV; // plus hold

    logic        CLK50MHZ = 1'b0;
    logic        RST = 1'b1;
    logic        BTN_WEST = 1'b0;
    logic        BTN_EAST = 1'b0;
    logic        SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR, BUSY, FRAME_DONE;
    logic [11:0] LEVEL;

    int checks = 0;
    int failures = 0;

    dac_btn_ctrl dut (
        .CLK50MHZ  (CLK50MHZ),
        .RST       (RST),
        .BTN_WEST  (BTN_WEST),
        .BTN_EAST  (BTN_EAST),
        .SPI_SCK   (SPI_SCK),
        .SPI_MOSI  (SPI_MOSI),
        .DAC_CS    (DAC_CS),
        .DAC_CLR   (DAC_CLR),
        .LEVEL     (LEVEL),
        .BUSY      (BUSY),
        .FRAME_DONE(FRAME_DONE)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    // inputs as seen by the DUT at the last rising edge
    logic rst_s, w_s, e_s;
    bit   seen = 1'b0;
    always @(posedge CLK50MHZ) begin
        rst_s <= RST;
        w_s   <= BTN_WEST;
        e_s   <= BTN_EAST;
        seen  <= 1'b1;
    end

    // model state
    int          cyc = 0;
    int          m_level;
    bit          m_pend, m_busy, m_clr;
    int          m_c;
    logic [31:0] m_word;
    bit          m_db[2];
    int          m_run[2];
    int          m_due[2];

    // monitor state
    logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0;
    int          bits = 0, cs_low = 0, done_cnt = 0, aborted = 0;
    int          busy_fall_cyc = 0, last_gap = 0, last_bits = 0;
    logic [31:0] sr = '0;
    logic [31:0] words[$];
    int          lows[$];

    always @(negedge CLK50MHZ) begin
        bit          raw[2];
        bit          hit[2];
        logic        e_sck, e_mosi, e_cs, e_done;
        logic [17:0] exp_v, got_v;
        if (seen) begin
            cyc++;
            raw[0] = w_s;
            raw[1] = e_s;
            if (rst_s) begin
                m_level = 0; m_pend = 0; m_busy = 0; m_c = 0; m_clr = 0;
                m_word = '0;
                for (int i = 0; i < 2; i++) begin
                    m_db[i] = 0; m_run[i] = 0; m_due[i] = -1;
                end
            end else begin
                m_clr = 1;
                // frame timeline: CS low FRAME_CS cycles, then DIV hold cycles
                if (m_busy) begin
                    m_c++;
                    if (m_c == FRAME_LEN) m_busy = 0;
                end else if (m_pend) begin
                    m_busy = 1; m_c = 0; m_pend = 0;
                    m_word = {8'h00, 4'b0011, 4'hF, 12'(m_level), 4'h0};
                end
                hit[0] = (m_due[0] == cyc);
                hit[1] = (m_due[1] == cyc);
                if (hit[0] && !hit[1] && m_level < 4095) begin
                    m_level = (m_level + 256 > 4095) ? 4095 : m_level + 256;
                    m_pend  = 1;
                end else if (hit[1] && !hit[0] && m_level > 0) begin
                    m_level = (m_level < 256) ? 0 : m_level - 256;
                    m_pend  = 1;
                end
                // DEB equal raw samples accepted; the level acts 3 edges later
                for (int i = 0; i < 2; i++) begin
                    if (raw[i] == m_db[i]) m_run[i] = 0;
                    else begin
                        m_run[i]++;
                        if (m_run[i] == DEB) begin
                            m_db[i]  = raw[i];
                            m_run[i] = 0;
                            if (raw[i]) m_due[i] = cyc + 3;
                        end
                    end
                end
            end

            e_sck = 0; e_mosi = 0; e_cs = 1;
            if (m_busy && m_c < FRAME_CS) begin
                e_cs   = 0;
                e_sck  = ((m_c / DIV) % 2) == 1;
                e_mosi = m_word[31 - m_c / (2 * DIV)];
            end
            e_done = m_busy && (m_c == FRAME_LEN - 1);
            exp_v = {e_sck, e_mosi, e_cs, m_clr, m_busy, e_done, 12'(m_level)};
            got_v = {SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR, BUSY, FRAME_DONE, LEVEL};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_model cyc=%0d got=%h exp=%h (sck,mosi,cs,clr,busy,done,level)",
                         cyc, got_v, exp_v);
            end

            // serial capture
            if (prev_cs && !DAC_CS) begin
                bits = 0; sr = '0; cs_low = 0;
                last_gap = cyc - busy_fall_cyc;
            end
            if (!DAC_CS) begin
                cs_low++;
                if (!prev_sck && SPI_SCK) begin
                    sr = {sr[30:0], SPI_MOSI};
                    bits++;
                end
            end
            if (!prev_cs && DAC_CS) begin
                last_bits = bits;
                if (bits == 32) begin
                    words.push_back(sr);
                    lows.push_back(cs_low);
                end else aborted++;
            end
            if (prev_busy && !BUSY) busy_fall_cyc = cyc;
            if (FRAME_DONE === 1'b1) done_cnt++;
            prev_sck  = SPI_SCK;
            prev_cs   = DAC_CS;
            prev_busy = BUSY;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic press(input bit west, input int hold);
        @(negedge CLK50MHZ);
        if (west) BTN_WEST = 1'b1; else BTN_EAST = 1'b1;
        repeat (hold) @(negedge CLK50MHZ);
        BTN_WEST = 1'b0;
        BTN_EAST = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK50MHZ);
        RST = 1'b1;
        repeat (n) @(negedge CLK50MHZ);
        RST = 1'b0;
        repeat (2) @(negedge CLK50MHZ);
    endtask

    initial begin
        int nw, nd, na, budget;

        // reset
        repeat (10) @(negedge CLK50MHZ);
        chk("rst_cs", 32'(DAC_CS), 32'd1);
        chk("rst_sck", 32'(SPI_SCK), 32'd0);
        chk("rst_clr", 32'(DAC_CLR), 32'd0);
        RST = 1'b0;
        @(negedge CLK50MHZ);
        chk("clr_release", 32'(DAC_CLR), 32'd1);
        chk("rst_level", 32'(LEVEL), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);

        // single west press
        nw = words.size(); nd = done_cnt;
        press(1, 50);
        repeat (300) @(negedge CLK50MHZ);
        chk("single_level", 32'(LEVEL), 32'd256);
        chk("single_frames", 32'(words.size() - nw), 32'd1);
        if (words.size() > nw) begin
            chk("single_word", words[$], 32'h003F1000);
            chk("single_cs_low", 32'(lows[$]), 32'd128);
        end
        chk("single_sck_rises", 32'(last_bits), 32'd32);
        chk("single_done", 32'(done_cnt - nd), 32'd1);

        // glitch shorter than debounce window
        nw = words.size();
        press(1, 10);
        repeat (100) @(negedge CLK50MHZ);
        chk("glitch_level", 32'(LEVEL), 32'd256);
        chk("glitch_frames", 32'(words.size() - nw), 32'd0);

        // saturation
        do_reset(3);
        for (int p = 1; p <= 17; p++) begin
            nw = words.size();
            press(1, 50);
            repeat (1950) @(negedge CLK50MHZ);
            if (p <= 16) chk("sat_frame", 32'(words.size() - nw), 32'd1);
            else         chk("sat_noframe", 32'(words.size() - nw), 32'd0);
            if (p == 16) begin
                chk("sat_level16", 32'(LEVEL), 32'd4095);
                chk("sat_word16", words[$], 32'h003FFFF0);
            end
        end
        chk("sat_level17", 32'(LEVEL), 32'd4095);
        press(0, 50);
        repeat (300) @(negedge CLK50MHZ);
        chk("east_level", 32'(LEVEL), 32'd3839);
        chk("east_word", words[$], 32'h003FEFF0);

        // merge: second press lands mid-shift
        do_reset(3);
        nw = words.size();
        press(1, 50);
        repeat (20) @(negedge CLK50MHZ);
        press(1, 50);
        repeat (400) @(negedge CLK50MHZ);
        chk("merge_frames", 32'(words.size() - nw), 32'd2);
        if (words.size() >= nw + 2) begin
            chk("merge_first", words[nw], 32'h003F1000);
            chk("merge_second", words[nw+1], 32'h003F2000);
        end
        chk("merge_gap", 32'(last_gap), 32'd1);
        chk("merge_level", 32'(LEVEL), 32'd512);

        // reset mid-frame at SCK rising edge 10
        do_reset(3);
        nd = done_cnt; na = aborted;
        press(1, 50);
        budget = 300;
        while (DAC_CS !== 1'b0 && budget > 0) begin @(negedge CLK50MHZ); budget--; end
        while (bits < 10 && budget > 0) begin @(negedge CLK50MHZ); budget--; end
        chk("wait_sck10", 32'(budget > 0), 32'd1);
        RST = 1'b1;
        @(negedge CLK50MHZ);
        chk("abort_cs", 32'(DAC_CS), 32'd1);
        chk("abort_sck", 32'(SPI_SCK), 32'd0);
        repeat (5) @(negedge CLK50MHZ);
        chk("abort_no_done", 32'(done_cnt - nd), 32'd0);
        chk("abort_seen", 32'(aborted - na), 32'd1);
        chk("abort_level", 32'(LEVEL), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK50MHZ);
        nw = words.size();
        press(1, 50);
        repeat (300) @(negedge CLK50MHZ);
        chk("post_abort_frames", 32'(words.size() - nw), 32'd1);
        if (words.size() > nw) chk("post_abort_word", words[$], 32'h003F1000);
        chk("post_abort_level", 32'(LEVEL), 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
